// File: rtl/node_tbl_pkg.sv
// Shared parameters, word offsets and FSM encoding for the neighbour table writer.
package node_tbl_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int ENTRY_WORDS = 4;
    localparam int WORD_WIDTH  = 16;
    localparam int INDEX_WIDTH = 6;
    localparam int ENTRY_BYTES = 8;

    localparam int ID_OFS     = 0;
    localparam int ENERGY_OFS = 2;
    localparam int HOP_OFS    = 4;
    localparam int Q_OFS      = 6;

    localparam int SLOT_WIDTH = $clog2(NUM_ENTRIES);
    localparam int CNT_WIDTH  = $clog2(ENTRY_WORDS);
    localparam int OCC_WIDTH  = $clog2(NUM_ENTRIES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_DONE,
        ST_DROP
    } tbl_state_t;

    // Byte index of word wsel inside entry slot; never exceeds 62, so index+1 cannot wrap.
    function automatic logic [INDEX_WIDTH-1:0] entry_index(input logic [SLOT_WIDTH-1:0] slot,
                                                            input logic [CNT_WIDTH-1:0]  wsel);
        return (INDEX_WIDTH'(slot) * INDEX_WIDTH'(ENTRY_BYTES)) + (INDEX_WIDTH'(wsel) << 1);
    endfunction

endpackage

// File: rtl/neighbor_table_writer.sv
// Receives 4-word neighbour packets, searches the 8-entry table in the node bank and
// overwrites the matching entry or fills the first free one; drops when the table is full.
//
// state    | meaning
// ST_IDLE  | ready, buffering packet words 0..3
// ST_SCAN  | reading entry IDs s=0..7, looking for a hit or first free slot
// ST_WRITE | writing buffered words w=0..3 into the chosen slot
// ST_DONE  | one-cycle update report
// ST_DROP  | one-cycle discard report
module neighbor_table_writer
    import node_tbl_pkg::*;
(
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [WORD_WIDTH-1:0]  pkt_data,
    output logic                   mem_wr_en,
    output logic [INDEX_WIDTH-1:0] mem_index,
    output logic [WORD_WIDTH-1:0]  mem_wdata,
    input  logic [WORD_WIDTH-1:0]  mem_rdata,
    output logic                   upd_done,
    output logic                   upd_hit,
    output logic [SLOT_WIDTH-1:0]  upd_slot,
    output logic                   upd_drop,
    output logic                   table_full
);

    tbl_state_t state_q, state_d;

    logic [WORD_WIDTH-1:0]  buf_q [ENTRY_WORDS];
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [SLOT_WIDTH-1:0]  scan_q;
    logic [CNT_WIDTH-1:0]   wcnt_q;
    logic [SLOT_WIDTH-1:0]  slot_q;
    logic                   hit_q;
    logic                   free_found_q;
    logic [SLOT_WIDTH-1:0]  free_slot_q;
    logic [OCC_WIDTH-1:0]   occ_q;
    logic                   full_q;

    logic                   accept;
    logic                   scan_hit;
    logic                   scan_free;
    logic                   scan_last;
    logic                   ready_c;
    logic                   wr_en_c;
    logic [INDEX_WIDTH-1:0] index_c;
    logic [WORD_WIDTH-1:0]  wdata_c;
    logic                   done_c;
    logic                   drop_c;

    assign accept    = pkt_valid && (state_q == ST_IDLE);
    assign scan_hit  = (mem_rdata == buf_q[0]);
    assign scan_free = (mem_rdata == '0);
    assign scan_last = (scan_q == SLOT_WIDTH'(NUM_ENTRIES - 1));

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        wr_en_c = 1'b0;
        index_c = '0;
        wdata_c = '0;
        done_c  = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (accept && (cnt_q == CNT_WIDTH'(ENTRY_WORDS - 1)))
                    state_d = (buf_q[0] == '0) ? ST_DROP : ST_SCAN;
            end
            ST_SCAN: begin
                index_c = entry_index(scan_q, CNT_WIDTH'(ID_OFS / 2));
                if (scan_hit)
                    state_d = ST_WRITE;
                else if (scan_last)
                    state_d = (free_found_q || scan_free) ? ST_WRITE : ST_DROP;
            end
            ST_WRITE: begin
                wr_en_c = 1'b1;
                index_c = entry_index(slot_q, wcnt_q);
                wdata_c = buf_q[wcnt_q];
                if (wcnt_q == CNT_WIDTH'(ENTRY_WORDS - 1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DROP: begin
                drop_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet buffer carries no reset; it is always refilled before being used.
    always_ff @(posedge clk) begin
        if (accept)
            buf_q[cnt_q] <= pkt_data;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            scan_q       <= '0;
            wcnt_q       <= '0;
            slot_q       <= '0;
            hit_q        <= 1'b0;
            free_found_q <= 1'b0;
            free_slot_q  <= '0;
            occ_q        <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= (occ_q == OCC_WIDTH'(NUM_ENTRIES));
            case (state_q)
                ST_IDLE: begin
                    if (accept)
                        cnt_q <= cnt_q + 1'b1;
                    scan_q       <= '0;
                    wcnt_q       <= '0;
                    hit_q        <= 1'b0;
                    free_found_q <= 1'b0;
                end
                ST_SCAN: begin
                    scan_q <= scan_q + 1'b1;
                    if (scan_hit) begin
                        slot_q <= scan_q;
                        hit_q  <= 1'b1;
                    end else begin
                        if (scan_free && !free_found_q) begin
                            free_found_q <= 1'b1;
                            free_slot_q  <= scan_q;
                        end
                        if (scan_last)
                            slot_q <= free_found_q ? free_slot_q : scan_q;
                    end
                end
                ST_WRITE: begin
                    wcnt_q <= wcnt_q + 1'b1;
                    if ((wcnt_q == CNT_WIDTH'(ENTRY_WORDS - 1)) && !hit_q &&
                        (occ_q != OCC_WIDTH'(NUM_ENTRIES)))
                        occ_q <= occ_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every output is forced low while reset is held, even before the state register clears.
    assign pkt_ready  = nrst & ready_c;
    assign mem_wr_en  = nrst & wr_en_c;
    assign mem_index  = nrst ? index_c : '0;
    assign mem_wdata  = nrst ? wdata_c : '0;
    assign upd_done   = nrst & done_c;
    assign upd_hit    = nrst & done_c & hit_q;
    assign upd_slot   = (nrst && done_c) ? slot_q : '0;
    assign upd_drop   = nrst & drop_c;
    assign table_full = nrst & full_q;

endmodule

// File: tb/tb_neighbor_table_writer.sv
// Directed bench for neighbor_table_writer with a behavioural 64-byte bank beside it.
module tb_neighbor_table_writer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [15:0] pkt_data = 16'h0000;
    logic        mem_wr_en;
    logic [5:0]  mem_index;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        upd_done;
    logic        upd_hit;
    logic [2:0]  upd_slot;
    logic        upd_drop;
    logic        table_full;

    logic [7:0]  bank [64];
    logic        bank_clear = 1'b0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    neighbor_table_writer dut (
        .clk        (clk),
        .nrst       (nrst),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .mem_wr_en  (mem_wr_en),
        .mem_index  (mem_index),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .upd_done   (upd_done),
        .upd_hit    (upd_hit),
        .upd_slot   (upd_slot),
        .upd_drop   (upd_drop),
        .table_full (table_full)
    );

    // Bank: big-endian 16-bit word at byte index/index+1, combinational read.
    assign mem_rdata = {bank[mem_index], bank[mem_index + 6'd1]};

    always @(posedge clk) begin
        if (bank_clear) begin
            for (int i = 0; i < 64; i++) bank[i] <= 8'h00;
        end else if (mem_wr_en) begin
            bank[mem_index]        <= mem_wdata[15:8];
            bank[mem_index + 6'd1] <= mem_wdata[7:0];
            wr_cnt                 <= wr_cnt + 1;
        end
    end

    function automatic logic [15:0] bank_word(input int idx);
        return {bank[idx], bank[idx + 1]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_and_clear();
        pkt_valid  = 1'b0;
        nrst       = 1'b0;
        bank_clear = 1'b1;
        @(posedge clk); #1;
        bank_clear = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input logic [15:0] w0, w1, w2, w3, input bit gap, input bit hold);
        logic [15:0] words [4];
        int n;
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                pkt_valid = 1'b0;
                pkt_data  = 16'hDEAD;
                @(posedge clk); #1;
            end
            pkt_valid = 1'b1;
            pkt_data  = words[i];
            n = 0;
            while (!pkt_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!pkt_ready) check("send_ready_timeout", pkt_ready, 1'b1);
            @(posedge clk); #1;
        end
        pkt_valid = hold;
        pkt_data  = hold ? 16'hBEEF : 16'h0000;
    endtask

    task automatic wait_result(output bit done, output bit drop, output bit hit,
                               output logic [2:0] slot, output int lat, output int writes);
        int w_start;
        w_start = wr_cnt;
        done = 1'b0; drop = 1'b0; hit = 1'b0; slot = 3'd0; lat = 0;
        for (int n = 0; n < 40; n++) begin
            lat++;
            if (upd_done || upd_drop) begin
                done = upd_done;
                drop = upd_drop;
                hit  = upd_hit;
                slot = upd_slot;
                break;
            end
            check("ready_low_busy", pkt_ready, 1'b0);
            @(posedge clk); #1;
        end
        writes = wr_cnt - w_start;
    endtask

    task automatic run_pkt(input string tag, input logic [15:0] w0, w1, w2, w3,
                           input bit gap, input bit hold, input bit exp_done,
                           input bit exp_hit, input logic [2:0] exp_slot,
                           input int exp_lat, input int exp_writes);
        bit done, drop, hit;
        logic [2:0] slot;
        int lat, writes;
        send_pkt(w0, w1, w2, w3, gap, hold);
        wait_result(done, drop, hit, slot, lat, writes);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_drop"}, drop, !exp_done);
        if (exp_done) begin
            check({tag, "_hit"}, hit, exp_hit);
            check({tag, "_slot"}, slot, exp_slot);
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_writes"}, writes, exp_writes);
        pkt_valid = 1'b0;
        pkt_data  = 16'h0000;
        @(posedge clk); #1;
        check({tag, "_ready_after"}, pkt_ready, 1'b1);
    endtask

    initial begin
        int n;

        // Reset state, with traffic offered during reset
        bank_clear = 1'b1;
        pkt_valid  = 1'b1;
        pkt_data   = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        bank_clear = 1'b0;
        check("reset_outputs",
              {pkt_ready, mem_wr_en, mem_index, mem_wdata, upd_done, upd_hit, upd_slot, upd_drop, table_full},
              '0);
        pkt_valid = 1'b0;
        pkt_data  = 16'h0000;
        nrst = 1'b1;
        @(posedge clk); #1;
        check("release_ready", pkt_ready, 1'b1);
        check("release_full", table_full, 1'b0);

        // 1: first insert into an empty bank
        run_pkt("t1", 16'h0011, 16'h0200, 16'h0003, 16'h7F00, 0, 0, 1, 0, 3'd0, 13, 4);
        check("t1_bytes", {bank[0], bank[1], bank[2], bank[3], bank[4], bank[5], bank[6], bank[7]},
              64'h0011_0200_0003_7F00);

        // 2: update of the same ID
        run_pkt("t2", 16'h0011, 16'h0150, 16'h0003, 16'h7F00, 0, 0, 1, 1, 3'd0, 6, 4);
        check("t2_energy", {bank[2], bank[3]}, 16'h0150);
        check("t2_slot1_empty", bank_word(8), 16'h0000);
        check("t2_full", table_full, 1'b0);

        // 3: fill all eight slots, then overflow and a hit on a full table
        reset_and_clear();
        for (int id = 1; id <= 8; id++) begin
            run_pkt($sformatf("t3_fill%0d", id), 16'(id), 16'(16'h0100 + id), 16'(id),
                    16'(16'h1000 + id), 0, 0, 1, 0, 3'(id - 1), 13, 4);
            check($sformatf("t3_id%0d", id), bank_word((id - 1) * 8), 16'(id));
            if (id == 7) check("t3_not_full", table_full, 1'b0);
        end
        check("t3_full", table_full, 1'b1);
        run_pkt("t3_drop9", 16'h0009, 16'h0999, 16'h0009, 16'h9999, 0, 0, 0, 0, 3'd0, 9, 0);
        check("t3_slot7_kept", bank_word(56), 16'h0008);
        run_pkt("t3_hit3", 16'h0003, 16'h0333, 16'h0033, 16'h3333, 0, 0, 1, 1, 3'd2, 8, 4);
        check("t3_hit3_energy", bank_word(18), 16'h0333);
        check("t3_hit3_q", bank_word(22), 16'h3333);
        check("t3_slot3_untouched", bank_word(26), 16'h0104);
        check("t3_full_after_hit", table_full, 1'b1);

        // 4: ID zero is dropped without scanning
        run_pkt("t4_id0", 16'h0000, 16'h0AAA, 16'h000A, 16'hAAAA, 0, 0, 0, 0, 3'd0, 1, 0);

        // 5: gapped valid with junk data between words, valid held high while busy
        run_pkt("t5_gap", 16'h0005, 16'h0555, 16'h0055, 16'h5555, 1, 1, 1, 1, 3'd4, 10, 4);
        check("t5_id", bank_word(32), 16'h0005);
        check("t5_energy", bank_word(34), 16'h0555);
        check("t5_hop", bank_word(36), 16'h0055);
        check("t5_q", bank_word(38), 16'h5555);

        // 6: reset while writing word 1
        reset_and_clear();
        send_pkt(16'h0077, 16'h0101, 16'h0202, 16'h0303, 0, 0);
        n = 0;
        while (!(mem_wr_en && mem_index == 6'd2) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_reach_w1", {mem_wr_en, mem_index}, {1'b1, 6'd2});
        nrst = 1'b0;
        @(posedge clk); #1;
        check("t6_reset_outputs",
              {pkt_ready, mem_wr_en, mem_index, mem_wdata, upd_done, upd_hit, upd_slot, upd_drop, table_full},
              '0);
        check("t6_partial_id", bank_word(0), 16'h0077);
        check("t6_partial_energy", bank_word(2), 16'h0000);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("t6_ready_release", pkt_ready, 1'b1);
        run_pkt("t6_after", 16'h0077, 16'h0A0A, 16'h0B0B, 16'h0C0C, 0, 0, 1, 1, 3'd0, 6, 4);
        check("t6_energy", bank_word(2), 16'h0A0A);
        check("t6_q", bank_word(6), 16'h0C0C);
        run_pkt("t6_new", 16'h0088, 16'h0808, 16'h0008, 16'h8888, 0, 0, 1, 0, 3'd1, 13, 4);
        check("t6_new_id", bank_word(8), 16'h0088);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
